// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
//   Accepts parallel words over a valid/ready handshake and buffers them in a
//   small FIFO. Emits each word one bit per clock, MSB first, on a registered
//   serial line. Queued words are sent back to back with no gap. The line idles
//   at 0 when nothing is queued.
//
// Ports
//   clk        : single clock, rising-edge
//   rst        : asynchronous, active-high reset
//   din        : parallel word to send
//   din_valid  : din is presented this cycle
//   din_ready  : FIFO can take a word (registered count != DEPTH)
//   x          : serial data bit (registered)
//   x_valid    : x carries a data bit this cycle (registered)
//   busy       : shifter active or FIFO non-empty
//   words_sent : count of fully transmitted words, wraps 255 -> 0
// ---------------------------------------------------------------------------
module bit_serializer #(
    parameter int WIDTH = 8,   // bits per word, >= 2
    parameter int DEPTH = 4    // FIFO entries, power of two, >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic [7:0]       words_sent
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // FIFO storage: no reset, contents are don't-care once pointers clear
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    state_t           state_q,  state_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic [7:0]       words_q, words_d;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;
    logic             fifo_nonempty;

    // ready is a function of the registered count only, so a pop on the
    // same edge never lets a push into a full FIFO
    assign din_ready     = (count_q != FULL);
    assign push          = din_valid && din_ready;
    assign fifo_nonempty = (count_q != '0);
    assign head          = mem_q[rd_ptr_q];

    // -----------------------------------------------------------------------
    // Next-state and datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        x_d       = x_q;
        x_valid_d = x_valid_q;
        words_d   = words_q;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                x_d       = 1'b0;
                x_valid_d = 1'b0;
                if (fifo_nonempty) begin
                    pop       = 1'b1;
                    shreg_d   = head;
                    x_d       = head[WIDTH-1];
                    x_valid_d = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q != LAST_BIT) begin
                    // x currently shows shreg_q[WIDTH-1]; next bit down is
                    // the MSB of the shifted register
                    shreg_d   = shreg_q << 1;
                    x_d       = shreg_q[WIDTH-2];
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end else begin
                    words_d = words_q + 8'd1;
                    if (fifo_nonempty) begin
                        // gapless hand-off to the next queued word
                        pop       = 1'b1;
                        shreg_d   = head;
                        x_d       = head[WIDTH-1];
                        x_valid_d = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        x_d       = 1'b0;
                        x_valid_d = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                x_d       = 1'b0;
                x_valid_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO pointer / count update
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            words_q   <= 8'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            words_q   <= words_d;
        end
    end

    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign busy       = (state_q == SHIFT) || fifo_nonempty;
    assign words_sent = words_q;

endmodule

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer
//   Directed + randomized bench. The reference model records, per accepted
//   word, the edge it was pushed and the edge its MSB leaves the FIFO:
//   start = max(push_edge + 1, previous_start + W). Every output after every
//   edge is derived from those times with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_bit_serializer;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         x;
    logic         x_valid;
    logic         busy;
    logic [7:0]   words_sent;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int           push_t_q [$];
    int           start_q  [$];
    logic [W-1:0] word_q   [$];

    bit_serializer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model queries ----------------
    function automatic int fifo_count(int t);
        int c = 0;
        foreach (push_t_q[i]) if (push_t_q[i] <= t) c++;
        foreach (start_q[i])  if (start_q[i]  <= t) c--;
        return c;
    endfunction

    function automatic int active_word(int t);
        foreach (start_q[i])
            if (start_q[i] <= t && t <= start_q[i] + W - 1) return i;
        return -1;
    endfunction

    function automatic int sent_at(int t);
        int c = 0;
        foreach (start_q[i]) if (start_q[i] + W <= t) c++;
        return c % 256;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        int   idx;
        int   c;
        logic eb;
        logic [W-1:0] w;
        idx = active_word(cyc);
        c   = fifo_count(cyc);
        eb  = 1'b0;
        if (idx >= 0) begin
            w  = word_q[idx];
            eb = w[W-1-(cyc-start_q[idx])];
        end
        chk("x",          {31'd0, x},         {31'd0, eb});
        chk("x_valid",    {31'd0, x_valid},   (idx >= 0) ? 32'd1 : 32'd0);
        chk("busy",       {31'd0, busy},      ((idx >= 0) || (c != 0)) ? 32'd1 : 32'd0);
        chk("din_ready",  {31'd0, din_ready}, (c != D) ? 32'd1 : 32'd0);
        chk("words_sent", {24'd0, words_sent}, sent_at(cyc));
    endtask

    // One clock: present inputs, take the edge, update model, check at +1.
    task automatic step(input logic v, input logic [W-1:0] d, output logic acc);
        int s;
        acc       = v && (fifo_count(cyc) != D);
        din_valid = v;
        din       = d;
        @(posedge clk);
        cyc++;
        if (acc) begin
            push_t_q.push_back(cyc);
            s = cyc + 1;
            if (start_q.size() > 0 && start_q[$] + W > s) s = start_q[$] + W;
            start_q.push_back(s);
            word_q.push_back(d);
        end
        #1;
        din_valid = 1'b0;
        line_out(v, d, acc);
        check_all();
    endtask

    task automatic line_out(input logic v, input logic [W-1:0] d, input logic acc);
        $display("cyc=%0d valid=%0b din=%02h acc=%0b x=%0b x_valid=%0b busy=%0b ready=%0b sent=%0d",
                 cyc, v, d, acc, x, x_valid, busy, din_ready, words_sent);
    endtask

    task automatic drain(input int max_cycles);
        logic a;
        for (int i = 0; i < max_cycles; i++) begin
            if (active_word(cyc) < 0 && fifo_count(cyc) == 0) break;
            step(1'b0, '0, a);
        end
        chk("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    // Reset asserted between edges, held for two edges, released between edges.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        push_t_q.delete();
        start_q.delete();
        word_q.delete();
        check_all();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            check_all();
        end
        rst = 1'b0;
    endtask

    initial begin
        logic a;
        int   accepted;
        int   guard;

        // reset state
        #1;
        check_all();
        @(posedge clk); cyc++; #1;
        check_all();
        rst = 1'b0;

        // single word, immediately after reset release
        step(1'b1, 8'hD0, a);
        chk("d0_accept", {31'd0, a}, 32'd1);
        drain(20);
        chk("single_sent", {24'd0, words_sent}, 32'd1);

        // back to back
        step(1'b1, 8'hA5, a);
        step(1'b1, 8'h3C, a);
        drain(30);

        // full and overflow: seven consecutive offers
        for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), a);
        drain(80);

        // reset mid-word with two words queued
        do_reset();
        step(1'b1, 8'hFF, a);
        step(1'b1, 8'hA1, a);
        step(1'b1, 8'hB2, a);
        step(1'b0, '0, a);
        do_reset();
        chk("rst_sent", {24'd0, words_sent}, 32'd0);
        for (int i = 0; i < 12; i++) step(1'b0, '0, a);
        step(1'b1, 8'($urandom), a);
        chk("post_rst_accept", {31'd0, a}, 32'd1);
        drain(30);

        // random traffic: mixed idle, push-on-pop, full FIFO
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), a);
        drain(80);

        // wrap: 260 words from a clean reset
        do_reset();
        accepted = 0;
        guard    = 0;
        while (accepted < 260 && guard < 5000) begin
            step(1'b1, 8'($urandom), a);
            if (a) accepted++;
            guard++;
        end
        chk("wrap_accepted", accepted, 32'd260);
        drain(80);
        chk("wrap_sent", {24'd0, words_sent}, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
